// File: rtl/uart_sort_frame_ctrl_pkg.sv
// Shared types and defaults for the UART-to-sorter frame controller.
// Frame on the wire: SYNC, LEN, LEN payload bytes, CSUM = XOR(LEN, payload).
package uart_sort_pkg;

  localparam int          N_MAX_DEF       = 16;
  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int          TIMEOUT_CYC_DEF = 100_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_START,
    ST_WAIT_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  function automatic logic len_ok(input logic [7:0] len, input int n_max);
    return (len != 8'd0) && (int'(len) <= n_max);
  endfunction

  // States in which a frame is being received and the inter-byte timer runs.
  function automatic logic in_frame(input frame_state_t s);
    return s inside {ST_LEN, ST_PAYLOAD, ST_CSUM};
  endfunction

endpackage

// File: rtl/uart_sort_frame_ctrl_if.sv
// Bundle between the UART receiver / sorter core and the frame controller.
// master = the controller's view, slave = the environment's view.
interface uart_sort_frame_ctrl_if
  import uart_sort_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEF
) ();
  localparam int ADDR_W = $clog2(N_MAX);
  localparam int LEN_W  = $clog2(N_MAX + 1);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic [LEN_W-1:0]  sort_len;
  logic              sort_start;
  logic              sort_done;
  logic              busy;
  logic              frame_err;
  err_code_t         err_code;
  logic [7:0]        drop_cnt;

  modport master (
    input  rx_data, rx_valid, sort_done,
    output buf_we, buf_addr, buf_wdata, sort_len, sort_start,
           busy, frame_err, err_code, drop_cnt
  );

  modport slave (
    output rx_data, rx_valid, sort_done,
    input  buf_we, buf_addr, buf_wdata, sort_len, sort_start,
           busy, frame_err, err_code, drop_cnt
  );
endinterface

// File: rtl/uart_sort_frame_ctrl_timeout_cnt.sv
// Inter-byte watchdog: loaded on every byte, counts down while a frame is open,
// and pulses o_expire on the cycle the quiet period reaches TIMEOUT_CYC-1 clocks.
module frame_timeout_cnt #(
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_load,
  input  logic i_clr,
  output logic o_expire
);
  localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = i_en && !i_load && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/uart_sort_frame_ctrl.sv
// Parses SYNC/LEN/payload/CSUM frames from the UART, streams the payload into
// the sorter buffer, launches one sort per good frame and waits for completion.
module uart_sort_frame_ctrl
  import uart_sort_pkg::*;
#(
  parameter int         N_MAX       = N_MAX_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  uart_sort_frame_ctrl_if.master bus
);
  localparam int ADDR_W = $clog2(N_MAX);
  localparam int LEN_W  = $clog2(N_MAX + 1);

  frame_state_t      r_state, w_next_state;
  logic [7:0]        r_csum, w_csum;
  logic [ADDR_W-1:0] r_idx, w_idx;

  logic              r_buf_we, w_buf_we;
  logic [ADDR_W-1:0] r_buf_addr, w_buf_addr;
  logic [7:0]        r_buf_wdata, w_buf_wdata;
  logic [LEN_W-1:0]  r_sort_len, w_sort_len;
  logic              r_sort_start, w_sort_start;
  logic              r_busy, w_busy;
  logic              r_frame_err, w_frame_err;
  err_code_t         r_err_code, w_err_code;
  logic [7:0]        r_drop_cnt, w_drop_cnt;

  logic w_expire, w_last, w_tmr_en, w_tmr_clr;

  assign w_tmr_en  = in_frame(r_state);
  assign w_tmr_clr = !in_frame(w_next_state);
  assign w_last    = (LEN_W'(r_idx) + LEN_W'(1)) == r_sort_len;

  frame_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_tmr_en),
    .i_load   (bus.rx_valid),
    .i_clr    (w_tmr_clr),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) w_next_state = ST_LEN;
      ST_LEN:
        if (bus.rx_valid)  w_next_state = len_ok(bus.rx_data, N_MAX) ? ST_PAYLOAD : ST_IDLE;
        else if (w_expire) w_next_state = ST_IDLE;
      ST_PAYLOAD:
        if (bus.rx_valid && w_last) w_next_state = ST_CSUM;
        else if (w_expire)          w_next_state = ST_IDLE;
      ST_CSUM:
        if (bus.rx_valid)  w_next_state = (bus.rx_data == r_csum) ? ST_START : ST_IDLE;
        else if (w_expire) w_next_state = ST_IDLE;
      ST_START:
        w_next_state = ST_WAIT_DONE;
      ST_WAIT_DONE:
        if (bus.sort_done) w_next_state = ST_IDLE;
      default:
        w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; pulses default low, held values default to their register.
  always_comb begin
    w_buf_we     = 1'b0;
    w_buf_addr   = r_buf_addr;
    w_buf_wdata  = r_buf_wdata;
    w_sort_len   = r_sort_len;
    w_sort_start = 1'b0;
    w_frame_err  = 1'b0;
    w_err_code   = r_err_code;
    w_drop_cnt   = r_drop_cnt;
    w_csum       = r_csum;
    w_idx        = r_idx;
    w_busy       = (w_next_state != ST_IDLE);
    case (r_state)
      ST_LEN:
        if (bus.rx_valid) begin
          if (len_ok(bus.rx_data, N_MAX)) begin
            w_sort_len = LEN_W'(bus.rx_data);
            w_csum     = bus.rx_data;
            w_idx      = '0;
          end else begin
            w_frame_err = 1'b1;
            w_err_code  = ERR_LEN;
          end
        end else if (w_expire) begin
          w_frame_err = 1'b1;
          w_err_code  = ERR_TIMEOUT;
        end
      ST_PAYLOAD:
        if (bus.rx_valid) begin
          w_buf_we    = 1'b1;
          w_buf_addr  = r_idx;
          w_buf_wdata = bus.rx_data;
          w_csum      = r_csum ^ bus.rx_data;
          w_idx       = r_idx + ADDR_W'(1);
        end else if (w_expire) begin
          w_frame_err = 1'b1;
          w_err_code  = ERR_TIMEOUT;
        end
      ST_CSUM:
        if (bus.rx_valid) begin
          if (bus.rx_data != r_csum) begin
            w_frame_err = 1'b1;
            w_err_code  = ERR_CSUM;
          end
        end else if (w_expire) begin
          w_frame_err = 1'b1;
          w_err_code  = ERR_TIMEOUT;
        end
      ST_START:
        w_sort_start = 1'b1;
      ST_WAIT_DONE:
        // Bytes arriving while the sorter owns the buffer are counted, never parsed.
        if (bus.rx_valid && (r_drop_cnt != 8'hFF)) w_drop_cnt = r_drop_cnt + 8'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_we     <= 1'b0;
      r_buf_addr   <= '0;
      r_buf_wdata  <= '0;
      r_sort_len   <= '0;
      r_sort_start <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_drop_cnt   <= '0;
      r_csum       <= '0;
      r_idx        <= '0;
    end else begin
      r_buf_we     <= w_buf_we;
      r_buf_addr   <= w_buf_addr;
      r_buf_wdata  <= w_buf_wdata;
      r_sort_len   <= w_sort_len;
      r_sort_start <= w_sort_start;
      r_busy       <= w_busy;
      r_frame_err  <= w_frame_err;
      r_err_code   <= w_err_code;
      r_drop_cnt   <= w_drop_cnt;
      r_csum       <= w_csum;
      r_idx        <= w_idx;
    end
  end

  assign bus.buf_we     = r_buf_we;
  assign bus.buf_addr   = r_buf_addr;
  assign bus.buf_wdata  = r_buf_wdata;
  assign bus.sort_len   = r_sort_len;
  assign bus.sort_start = r_sort_start;
  assign bus.busy       = r_busy;
  assign bus.frame_err  = r_frame_err;
  assign bus.err_code   = r_err_code;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_uart_sort_frame_ctrl.sv
// Self-checking bench for uart_sort_frame_ctrl: directed scenarios plus random
// frames scored against a frame-level reference model.
module tb_uart_sort_frame_ctrl;
  import uart_sort_pkg::*;

  localparam int N_MAX = 16;
  localparam int TO    = 40;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_sort_frame_ctrl_if #(.N_MAX(N_MAX)) bus ();

  uart_sort_frame_ctrl #(.N_MAX(N_MAX), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_stamp = 0;
  int exp_drop = 0;
  int wr_addr[$], wr_data[$], start_cyc[$], err_cyc[$], err_val[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.buf_we) begin
        wr_addr.push_back(int'(bus.buf_addr));
        wr_data.push_back(int'(bus.buf_wdata));
      end
      if (bus.sort_start) start_cyc.push_back(cyc);
      if (bus.frame_err) begin
        err_cyc.push_back(cyc);
        err_val.push_back(int'(bus.err_code));
      end
    end
  end

  // Reference model: error class of a whole frame from the framing rules.
  function automatic int expect_err(input bq_t f);
    int len;
    logic [7:0] cs;
    len = int'(f[1]);
    if (len == 0 || len > N_MAX) return 1;
    cs = f[1];
    for (int i = 0; i < len; i++) cs ^= f[2+i];
    return (f[2+len] == cs) ? 0 : 2;
  endfunction

  function automatic bq_t make_frame(input bq_t payload, input logic [7:0] csum_flip);
    bq_t f;
    logic [7:0] cs;
    cs = 8'(payload.size());
    f.push_back(8'hA5);
    f.push_back(cs);
    foreach (payload[i]) begin
      f.push_back(payload[i]);
      cs ^= payload[i];
    end
    f.push_back(cs ^ csum_flip);
    return f;
  endfunction

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); start_cyc.delete();
    err_cyc.delete(); err_val.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic done = 1'b0);
    @(negedge clk);
    bus.rx_data = b; bus.rx_valid = 1'b1; bus.sort_done = done;
    last_stamp = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.sort_done = 1'b0;
  endtask

  task automatic send_frame(input bq_t f);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic pulse_done();
    @(negedge clk); bus.sort_done = 1'b1;
    @(negedge clk); bus.sort_done = 1'b0;
  endtask

  task automatic add_drops(input int n);
    exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
  endtask

  task automatic test_reset();
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.sort_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.sort_len, bus.sort_start, bus.busy,
         bus.frame_err, bus.err_code, bus.drop_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs: got busy=%b len=%0d drop=%0d want all zero",
                      bus.busy, bus.sort_len, bus.drop_cnt);
    end
    rst_n = 1'b1;
    exp_drop = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    bq_t f = '{8'hA5, 8'h04, 8'h10, 8'h03, 8'h22, 8'h01, 8'h34};
    int s;
    clear_logs();
    send_frame(f);
    s = last_stamp;
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr.size() !== 4) begin bad++; $display("FAIL good_wr_count: got %0d want 4", wr_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_addr[i] !== i || wr_data[i] !== int'(f[2+i])) begin
        bad++; $display("FAIL good_wr[%0d]: got a=%0d d=%h want a=%0d d=%h", i, wr_addr[i], wr_data[i], i, f[2+i]);
      end
    end
    total++;
    if (bus.sort_len !== 5'd4) begin bad++; $display("FAIL good_sort_len: got %0d want 4", bus.sort_len); end
    total++;
    if (start_cyc.size() !== 1 || start_cyc[0] !== s + 2) begin
      bad++; $display("FAIL good_start_latency: got n=%0d cyc=%0d want n=1 cyc=%0d",
                      start_cyc.size(), (start_cyc.size() > 0) ? start_cyc[0] : -1, s + 2);
    end
    total++;
    if (err_cyc.size() !== 0) begin bad++; $display("FAIL good_no_err: got %0d errs want 0", err_cyc.size()); end
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL good_busy_wait: got %b want 1", bus.busy); end
    pulse_done();
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL good_busy_after_done: got %b want 0", bus.busy); end
  endtask

  task automatic test_bad_csum();
    bq_t f = '{8'hA5, 8'h04, 8'h10, 8'h03, 8'h22, 8'h01, 8'h35};
    bq_t g = '{8'hA5, 8'h04, 8'h10, 8'h03, 8'h22, 8'h01, 8'h34};
    int s;
    clear_logs();
    send_frame(f);
    s = last_stamp;
    repeat (3) @(negedge clk);
    total++;
    if (err_cyc.size() !== 1 || err_val[0] !== 2 || err_cyc[0] !== s + 1) begin
      bad++; $display("FAIL csum_err: got n=%0d want n=1 code=2 at cyc %0d", err_cyc.size(), s + 1);
    end
    total++;
    if (start_cyc.size() !== 0 || wr_addr.size() !== 4) begin
      bad++; $display("FAIL csum_side: got starts=%0d writes=%0d want 0 and 4", start_cyc.size(), wr_addr.size());
    end
    total++;
    if (bus.err_code !== ERR_CSUM || bus.busy !== 1'b0) begin
      bad++; $display("FAIL csum_hold: got code=%0d busy=%b want 2 and 0", bus.err_code, bus.busy);
    end
    clear_logs();
    send_frame(g);
    repeat (3) @(negedge clk);
    total++;
    if (start_cyc.size() !== 1 || err_cyc.size() !== 0) begin
      bad++; $display("FAIL csum_recover: got starts=%0d errs=%0d want 1 and 0", start_cyc.size(), err_cyc.size());
    end
    pulse_done();
  endtask

  task automatic test_bad_len();
    clear_logs();
    send_frame('{8'hA5, 8'h00});
    send_frame('{8'hA5, 8'h11});
    repeat (3) @(negedge clk);
    total++;
    if (err_cyc.size() !== 2 || err_val[0] !== 1 || err_val[1] !== 1) begin
      bad++; $display("FAIL len_err: got n=%0d want 2 errors with code 1", err_cyc.size());
    end
    total++;
    if (wr_addr.size() !== 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL len_side: got writes=%0d busy=%b want 0 and 0", wr_addr.size(), bus.busy);
    end
  endtask

  task automatic test_timeout();
    int s;
    clear_logs();
    send_frame('{8'hA5, 8'h03, 8'h7F});
    s = last_stamp;
    repeat (TO + 5) @(negedge clk);
    total++;
    if (err_cyc.size() !== 1 || err_val[0] !== 3 || err_cyc[0] !== s + TO) begin
      bad++; $display("FAIL timeout_err: got n=%0d cyc=%0d want n=1 code=3 cyc=%0d",
                      err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, s + TO);
    end
    total++;
    if (bus.busy !== 1'b0 || wr_addr.size() !== 1) begin
      bad++; $display("FAIL timeout_side: got busy=%b writes=%0d want 0 and 1", bus.busy, wr_addr.size());
    end
  endtask

  task automatic test_busy_drop();
    bq_t g = '{8'hA5, 8'h02, 8'hA5, 8'h09, 8'hAE};
    clear_logs();
    send_frame(g);
    repeat (3) @(negedge clk);
    send_byte(8'h11);
    send_byte(8'hA5);
    send_byte(8'h22, 1'b1);
    add_drops(3);
    @(negedge clk);
    total++;
    if (bus.drop_cnt !== 8'(exp_drop) || bus.busy !== 1'b0) begin
      bad++; $display("FAIL drop_cnt: got %0d busy=%b want %0d busy=0", bus.drop_cnt, bus.busy, exp_drop);
    end
    total++;
    if (bus.err_code !== ERR_TIMEOUT) begin
      bad++; $display("FAIL err_code_hold: got %0d want 3", bus.err_code);
    end
    clear_logs();
    send_frame(g);
    repeat (3) @(negedge clk);
    total++;
    if (start_cyc.size() !== 1 || wr_addr.size() !== 2 || bus.sort_len !== 5'd2) begin
      bad++; $display("FAIL drop_next_frame: got starts=%0d writes=%0d len=%0d want 1 2 2",
                      start_cyc.size(), wr_addr.size(), bus.sort_len);
    end
    pulse_done();
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      bq_t pl, f;
      int kind, len, e, nd;
      logic [7:0] flip;
      kind = $urandom_range(0, 9);
      clear_logs();
      if ($urandom_range(0, 3) == 0) send_byte(8'h3C);
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(N_MAX + 1, 255);
        f = '{8'hA5, 8'(len)};
        send_frame(f);
        e = 1;
      end else begin
        len = $urandom_range(1, N_MAX);
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        flip = (kind <= 3) ? 8'($urandom_range(1, 255)) : 8'h00;
        f = make_frame(pl, flip);
        send_frame(f);
        e = expect_err(f);
      end
      repeat (3) @(negedge clk);
      total++;
      if (err_cyc.size() !== ((e != 0) ? 1 : 0) || (e != 0 && err_val[0] !== e)) begin
        bad++; $display("FAIL rnd%0d_err: got n=%0d want code %0d", it, err_cyc.size(), e);
      end
      total++;
      if (wr_addr.size() !== ((e == 1) ? 0 : len)) begin
        bad++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", it, wr_addr.size(), (e == 1) ? 0 : len);
      end else if (e != 1) begin
        for (int i = 0; i < len; i++) begin
          total++;
          if (wr_addr[i] !== i || wr_data[i] !== int'(pl[i])) begin
            bad++; $display("FAIL rnd%0d_wr[%0d]: got a=%0d d=%h want a=%0d d=%h", it, i, wr_addr[i], wr_data[i], i, pl[i]);
          end
        end
      end
      total++;
      if (start_cyc.size() !== ((e == 0) ? 1 : 0)) begin
        bad++; $display("FAIL rnd%0d_start: got %0d want %0d", it, start_cyc.size(), (e == 0) ? 1 : 0);
      end
      if (e == 0) begin
        total++;
        if (int'(bus.sort_len) !== len) begin bad++; $display("FAIL rnd%0d_len: got %0d want %0d", it, bus.sort_len, len); end
        nd = $urandom_range(0, 3);
        for (int k = 0; k < nd; k++) send_byte(8'($urandom), (k == nd - 1) && ($urandom_range(0, 1) == 1));
        add_drops(nd);
        pulse_done();
      end
      @(negedge clk);
      total++;
      if (bus.drop_cnt !== 8'(exp_drop) || bus.busy !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_drop: got %0d busy=%b want %0d busy=0", it, bus.drop_cnt, bus.busy, exp_drop);
      end
    end
  endtask

  task automatic test_drop_saturate();
    send_frame('{8'hA5, 8'h01, 8'h07, 8'h06});
    repeat (3) @(negedge clk);
    for (int k = 0; k < 260; k++) send_byte(8'($urandom));
    add_drops(260);
    total++;
    if (bus.drop_cnt !== 8'(exp_drop) || exp_drop != 255) begin
      bad++; $display("FAIL drop_saturate: got %0d want 255", bus.drop_cnt);
    end
    pulse_done();
  endtask

  task automatic test_async_reset();
    clear_logs();
    send_frame('{8'hA5, 8'h05, 8'h11, 8'h22});
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL arst_busy_before: got %b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.sort_len, bus.sort_start, bus.busy,
         bus.frame_err, bus.err_code, bus.drop_cnt} !== '0) begin
      bad++; $display("FAIL arst_outputs: got busy=%b len=%0d drop=%0d want all zero",
                      bus.busy, bus.sort_len, bus.drop_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_drop = 0;
    clear_logs();
    send_frame('{8'hA5, 8'h01, 8'h55, 8'h54});
    repeat (3) @(negedge clk);
    total++;
    if (bus.sort_len !== 5'd1 || start_cyc.size() !== 1 || wr_addr.size() !== 1 || wr_data[0] !== 'h55) begin
      bad++; $display("FAIL arst_new_frame: got len=%0d starts=%0d writes=%0d want 1 1 1",
                      bus.sort_len, start_cyc.size(), wr_addr.size());
    end
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_busy_drop();
    test_random();
    test_drop_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
